// File: rtl/imu_spi_sampler_pkg.sv
//------------------------------------------------------------------------------
// imu_spi_sampler_pkg : command bytes, frame lengths, FSM encoding    rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package imu_spi_sampler_pkg;

  localparam logic [7:0] GYRO_CMD     = 8'hE8;  // read, auto-increment, 0x28
  localparam logic [7:0] ACCEL_CMD    = 8'hF4;  // read, multi-byte, 0x34
  localparam logic [7:0] DUMMY_BYTE   = 8'h00;
  localparam int         GYRO_NBYTES  = 3;
  localparam int         ACCEL_NBYTES = 5;
  localparam int         BYTE_IDX_W   = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_G_SETUP = 4'd1,
    ST_G_XFER  = 4'd2,
    ST_G_HOLD  = 4'd3,
    ST_GAP     = 4'd4,
    ST_A_SETUP = 4'd5,
    ST_A_XFER  = 4'd6,
    ST_A_HOLD  = 4'd7,
    ST_PUBLISH = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imu_spi_sampler_shifter.sv
//------------------------------------------------------------------------------
// spi_byte_shifter : one-byte SPI mode-3 master shifter, start/done     rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_data
);

  logic       r_busy;
  logic       r_sclk;
  logic       r_mosi;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic [7:0] r_rx;
  logic       w_half_end;

  assign w_half_end = (r_div == 8'(CLK_DIV - 1));
  // Last cycle of the high half of bit 7; a start here chains bytes gap-free.
  assign done    = r_busy && r_sclk && w_half_end && (r_bit == 3'd7);
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign rx_data = r_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_sclk <= 1'b1;
      r_mosi <= 1'b0;
      r_div  <= 8'd0;
      r_bit  <= 3'd0;
      r_sh   <= 8'd0;
      r_rx   <= 8'd0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_sclk <= 1'b0;
      r_mosi <= tx_data[7];
      r_sh   <= tx_data;
      r_div  <= 8'd0;
      r_bit  <= 3'd0;
    end else if (r_busy) begin
      if (w_half_end) begin
        r_div <= 8'd0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], miso};
        end else if (r_bit == 3'd7) begin
          r_busy <= 1'b0;
          r_mosi <= 1'b0;
        end else begin
          r_sclk <= 1'b0;
          r_mosi <= r_sh[6];
          r_sh   <= {r_sh[6:0], 1'b0};
          r_bit  <= r_bit + 3'd1;
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imu_spi_sampler.sv
//------------------------------------------------------------------------------
// imu_spi_sampler : periodic gyro X / accel Y,Z reader over shared SPI  rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module imu_spi_sampler
  import imu_spi_sampler_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic        clk,
  input  logic        RST,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        gyro_cs_n,
  output logic        accel_cs_n,
  output logic [15:0] gyroData,
  output logic [15:0] y_accel_data,
  output logic [15:0] z_accel_data,
  output logic        data_valid,
  output logic        overrun
);

  localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  state_t                r_state;
  logic [TW-1:0]         r_tick_cnt;
  logic [7:0]            r_div_cnt;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic                  r_gyro_cs_n;
  logic                  r_accel_cs_n;
  logic [15:0]           r_gyro_sh;
  logic [15:0]           r_y_sh;
  logic [15:0]           r_z_sh;
  logic [15:0]           r_gyro_data;
  logic [15:0]           r_y_data;
  logic [15:0]           r_z_data;
  logic                  r_data_valid;
  logic                  r_overrun;

  logic                  w_tick;
  logic                  w_div_end;
  logic                  w_start;
  logic [7:0]            w_tx;
  logic                  w_done;
  logic [7:0]            w_rx;

  assign w_tick    = (r_tick_cnt == '0);
  assign w_div_end = (r_div_cnt == 8'(CLK_DIV - 1));

  // Reset loads 1 so the first tick lands SAMPLE_DIV-1 cycles after release.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_tick_cnt <= TW'(1);
    end else if (r_tick_cnt == TW'(SAMPLE_DIV - 1)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_comb begin
    w_start = 1'b0;
    w_tx    = DUMMY_BYTE;
    case (r_state)
      ST_G_SETUP: if (w_div_end) begin
        w_start = 1'b1;
        w_tx    = GYRO_CMD;
      end
      ST_A_SETUP: if (w_div_end) begin
        w_start = 1'b1;
        w_tx    = ACCEL_CMD;
      end
      ST_G_XFER: w_start = w_done && (r_byte_idx != BYTE_IDX_W'(GYRO_NBYTES - 1));
      ST_A_XFER: w_start = w_done && (r_byte_idx != BYTE_IDX_W'(ACCEL_NBYTES - 1));
      default: ;
    endcase
  end

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (RST),
    .start   (w_start),
    .tx_data (w_tx),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .done    (w_done),
    .rx_data (w_rx)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_div_cnt    <= 8'd0;
      r_byte_idx   <= '0;
      r_gyro_cs_n  <= 1'b1;
      r_accel_cs_n <= 1'b1;
      r_gyro_sh    <= 16'd0;
      r_y_sh       <= 16'd0;
      r_z_sh       <= 16'd0;
      r_gyro_data  <= 16'd0;
      r_y_data     <= 16'd0;
      r_z_data     <= 16'd0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      // Any tick outside IDLE (including PUBLISH) is dropped and flagged.
      r_overrun    <= w_tick && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: if (w_tick) begin
          r_state     <= ST_G_SETUP;
          r_gyro_cs_n <= 1'b0;
          r_div_cnt   <= 8'd0;
        end
        ST_G_SETUP: if (w_div_end) begin
          r_state    <= ST_G_XFER;
          r_byte_idx <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
        ST_G_XFER: if (w_done) begin
          case (r_byte_idx)
            BYTE_IDX_W'(1): r_gyro_sh[7:0]  <= w_rx;
            BYTE_IDX_W'(2): r_gyro_sh[15:8] <= w_rx;
            default: ;
          endcase
          if (r_byte_idx == BYTE_IDX_W'(GYRO_NBYTES - 1)) begin
            r_state   <= ST_G_HOLD;
            r_div_cnt <= 8'd0;
          end else begin
            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
          end
        end
        ST_G_HOLD: if (w_div_end) begin
          r_state     <= ST_GAP;
          r_gyro_cs_n <= 1'b1;
          r_div_cnt   <= 8'd0;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
        ST_GAP: if (w_div_end) begin
          r_state      <= ST_A_SETUP;
          r_accel_cs_n <= 1'b0;
          r_div_cnt    <= 8'd0;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
        ST_A_SETUP: if (w_div_end) begin
          r_state    <= ST_A_XFER;
          r_byte_idx <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
        ST_A_XFER: if (w_done) begin
          case (r_byte_idx)
            BYTE_IDX_W'(1): r_y_sh[7:0]  <= w_rx;
            BYTE_IDX_W'(2): r_y_sh[15:8] <= w_rx;
            BYTE_IDX_W'(3): r_z_sh[7:0]  <= w_rx;
            BYTE_IDX_W'(4): r_z_sh[15:8] <= w_rx;
            default: ;
          endcase
          if (r_byte_idx == BYTE_IDX_W'(ACCEL_NBYTES - 1)) begin
            r_state   <= ST_A_HOLD;
            r_div_cnt <= 8'd0;
          end else begin
            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
          end
        end
        ST_A_HOLD: if (w_div_end) begin
          r_state      <= ST_PUBLISH;
          r_accel_cs_n <= 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
        end
        ST_PUBLISH: begin
          r_gyro_data  <= r_gyro_sh;
          r_y_data     <= r_y_sh;
          r_z_data     <= r_z_sh;
          r_data_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gyro_cs_n    = r_gyro_cs_n;
  assign accel_cs_n   = r_accel_cs_n;
  assign gyroData     = r_gyro_data;
  assign y_accel_data = r_y_data;
  assign z_accel_data = r_z_data;
  assign data_valid   = r_data_valid;
  assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_imu_spi_sampler.sv
//------------------------------------------------------------------------------
// tb_imu_spi_sampler : directed bench with gyro/accel slave models      rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_imu_spi_sampler;

  localparam int CLK_DIV      = 2;
  localparam int SAMPLE_DIV   = 400;
  localparam int SAMPLE_DIV_B = 200;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;

  logic        sclk_a, mosi_a, miso_a, gcs_a, acs_a, dv_a, ov_a;
  logic [15:0] gx_a, ya_a, za_a;
  logic        sclk_b, mosi_b, gcs_b, acs_b, dv_b, ov_b;
  logic        miso_b = 1'b1;
  logic [15:0] gx_b, ya_b, za_b;

  imu_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV)) u_dut_a (
    .clk(clk), .RST(RST), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
    .gyro_cs_n(gcs_a), .accel_cs_n(acs_a), .gyroData(gx_a), .y_accel_data(ya_a),
    .z_accel_data(za_a), .data_valid(dv_a), .overrun(ov_a)
  );

  imu_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV_B)) u_dut_b (
    .clk(clk), .RST(RST), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b),
    .gyro_cs_n(gcs_b), .accel_cs_n(acs_b), .gyroData(gx_b), .y_accel_data(ya_b),
    .z_accel_data(za_b), .data_valid(dv_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave models and bus monitors for DUT A, light monitors for DUT B.
  logic [15:0] m_gx, m_ya, m_za;
  logic [23:0] g_sh = '0, g_cap = '0, g_cap_last = '0, b_gcap = '0, b_gcap_last = '0;
  logic [39:0] a_sh = '0, a_cap = '0, a_cap_last = '0;
  logic        g_bit = 1'b0, a_bit = 1'b0;
  logic        p_gcs = 1'b1, p_acs = 1'b1, p_sclk = 1'b1, p_sclk_b = 1'b1, p_gcs_b = 1'b1;
  logic        p_dv = 1'b0, rst_edge = 1'b1;
  logic [47:0] prev_out = '0;
  int g_edges = 0, a_edges = 0, g_edges_last = 0, a_edges_last = 0, g_fall_cyc = 0;
  int ovl_err = 0, sclk_err = 0, chg_err = 0, dv_wide_err = 0, a_ov_cnt = 0;
  int b_ov_cnt = 0, b_dv_cnt = 0, b_first_ov = -1, b_first_dv = -1;

  assign miso_a = !gcs_a ? g_bit : (!acs_a ? a_bit : 1'b0);

  always @(posedge clk) rst_edge <= RST;

  always @(negedge clk) begin
    if (p_gcs && !gcs_a) begin
      g_sh       <= {8'h00, m_gx[7:0], m_gx[15:8]};
      g_cap      <= '0;
      g_edges    <= 0;
      g_fall_cyc <= cyc;
    end
    if (p_acs && !acs_a) begin
      a_sh    <= {8'h00, m_ya[7:0], m_ya[15:8], m_za[7:0], m_za[15:8]};
      a_cap   <= '0;
      a_edges <= 0;
    end
    if (p_sclk && !sclk_a && !gcs_a) begin
      g_bit <= g_sh[23];
      g_sh  <= {g_sh[22:0], 1'b0};
    end
    if (p_sclk && !sclk_a && !acs_a) begin
      a_bit <= a_sh[39];
      a_sh  <= {a_sh[38:0], 1'b0};
    end
    if (!p_sclk && sclk_a && !gcs_a) begin
      g_cap   <= {g_cap[22:0], mosi_a};
      g_edges <= g_edges + 1;
    end
    if (!p_sclk && sclk_a && !acs_a) begin
      a_cap   <= {a_cap[38:0], mosi_a};
      a_edges <= a_edges + 1;
    end
    if (!p_gcs && gcs_a) begin
      g_cap_last   <= g_cap;
      g_edges_last <= g_edges;
    end
    if (!p_acs && acs_a) begin
      a_cap_last   <= a_cap;
      a_edges_last <= a_edges;
    end
    if (!p_sclk_b && sclk_b && !gcs_b) b_gcap <= {b_gcap[22:0], mosi_b};
    if (!p_gcs_b && gcs_b) b_gcap_last <= b_gcap;
    if ((!gcs_a && !acs_a) || (!gcs_b && !acs_b)) ovl_err <= ovl_err + 1;
    if ((gcs_a && acs_a && sclk_a !== 1'b1) || (gcs_b && acs_b && sclk_b !== 1'b1))
      sclk_err <= sclk_err + 1;
    if ({gx_a, ya_a, za_a} !== prev_out && !dv_a && !rst_edge) chg_err <= chg_err + 1;
    if (dv_a && p_dv) dv_wide_err <= dv_wide_err + 1;
    if (ov_a) a_ov_cnt <= a_ov_cnt + 1;
    if (ov_b) b_ov_cnt <= b_ov_cnt + 1;
    if (dv_b) b_dv_cnt <= b_dv_cnt + 1;
    if (ov_b && b_first_ov < 0) b_first_ov <= cyc;
    if (dv_b && b_first_dv < 0) b_first_dv <= cyc;
    prev_out <= {gx_a, ya_a, za_a};
    p_dv     <= dv_a;
    p_gcs    <= gcs_a;
    p_acs    <= acs_a;
    p_sclk   <= sclk_a;
    p_sclk_b <= sclk_b;
    p_gcs_b  <= gcs_b;
  end

  task automatic wait_dv(input int budget, output int t, output logic found,
                         output logic [15:0] pre_gx);
    found  = 1'b0;
    t      = 0;
    pre_gx = gx_a;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (dv_a) begin
        found = 1'b1;
        t     = cyc;
      end else begin
        pre_gx = gx_a;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1);
  end

  initial begin
    int k0, k1, t;
    logic found, seen;
    logic [15:0] pre;

    m_gx = 16'h1234; m_ya = 16'hFF80; m_za = 16'h0100;
    RST  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk_a, 1'b1);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_gcs", gcs_a, 1'b1);
    check("rst_acs", acs_a, 1'b1);
    check("rst_dv_ov", {dv_a, ov_a}, 2'b00);
    check("rst_data", {gx_a, ya_a, za_a}, 48'h0);
    k0  = cyc;
    RST = 1'b0;

    // Frame 1: tick at k0+399, CS at +1, data_valid 268 cycles after tick.
    wait_dv(1000, t, found, pre);
    check("f1_found", found, 1'b1);
    check("f1_gcs_fall", 64'(g_fall_cyc - k0), 64'd400);
    check("f1_latency", 64'(t - k0), 64'd667);
    check("f1_hold_before", pre, 16'h0000);
    check("f1_gyro", gx_a, 16'h1234);
    check("f1_y", ya_a, 16'hFF80);
    check("f1_z", za_a, 16'h0100);
    check("f1_mosi_gyro", g_cap_last, 24'hE80000);
    check("f1_mosi_accel", a_cap_last, 40'hF400000000);
    check("f1_edges_gyro", 64'(g_edges_last), 64'd24);
    check("f1_edges_accel", 64'(a_edges_last), 64'd40);
    @(negedge clk);
    check("f1_dv_one_cycle", dv_a, 1'b0);

    // Frame 2: positive full-scale.
    m_gx = 16'h7FFF;
    wait_dv(1000, t, found, pre);
    check("f2_found", found, 1'b1);
    check("f2_latency", 64'(t - k0), 64'd1067);
    check("f2_hold_before", pre, 16'h1234);
    check("f2_gyro", gx_a, 16'h7FFF);

    // Short-period instance: overruns on alternate ticks, every frame completes.
    check("b_overruns", 64'(b_ov_cnt), 64'd2);
    check("b_frames", 64'(b_dv_cnt), 64'd2);
    check("b_first_ov", 64'(b_first_ov - k0), 64'd400);
    check("b_first_dv", 64'(b_first_dv - k0), 64'd467);
    check("b_data", {gx_b, ya_b, za_b}, 48'hFFFF_FFFF_FFFF);
    check("b_mosi_gyro", b_gcap_last, 24'hE80000);

    // Frame 3: negative full-scale.
    m_gx = 16'h8000;
    wait_dv(1000, t, found, pre);
    check("f3_found", found, 1'b1);
    check("f3_hold_before", pre, 16'h7FFF);
    check("f3_gyro", gx_a, 16'h8000);
    check("f3_yz", {ya_a, za_a}, 32'hFF80_0100);

    // Frame 4: abort with a one-cycle reset inside the second accel byte.
    m_gx = 16'h5555;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (!acs_a) seen = 1'b1;
    end
    check("f4_acs_seen", seen, 1'b1);
    repeat (2 + 32 + 8) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    k1  = cyc;
    RST = 1'b0;
    check("abort_cs", {gcs_a, acs_a}, 2'b11);
    check("abort_sclk", sclk_a, 1'b1);
    check("abort_dv", dv_a, 1'b0);
    check("abort_data", {gx_a, ya_a, za_a}, 48'h0);

    m_gx = 16'h0BAD; m_ya = 16'h2468; m_za = 16'hFEDC;
    wait_dv(1000, t, found, pre);
    check("f5_found", found, 1'b1);
    check("f5_latency", 64'(t - k1), 64'd667);
    check("f5_hold_before", pre, 16'h0000);
    check("f5_data", {gx_a, ya_a, za_a}, 48'h0BAD_2468_FEDC);

    repeat (2) @(negedge clk);
    check("cs_overlap", 64'(ovl_err), 64'd0);
    check("sclk_idle_high", 64'(sclk_err), 64'd0);
    check("outputs_change_only_on_dv", 64'(chg_err), 64'd0);
    check("dv_single_cycle", 64'(dv_wide_err), 64'd0);
    check("a_no_overrun", 64'(a_ov_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imu_spi_sampler.md
IMU_SPI_SAMPLER -- requirements
Module: imu_spi_sampler

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCLK half-period; legal range 2..255.
REQ-002 Parameter SAMPLE_DIV, default 5000: system clocks per sample tick (10 kHz at 50 MHz, dt = 0.0001 s); must exceed 133*CLK_DIV+2.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 spi_sclk  out  1  shared SPI clock, mode 3 (CPOL=1, CPHA=1).
REQ-006 spi_mosi  out  1  shared master-out data.
REQ-007 spi_miso  in  1  shared master-in data, assumed synchronised externally.
REQ-008 gyro_cs_n  out  1  gyro chip select, active-low.
REQ-009 accel_cs_n  out  1  accelerometer chip select, active-low.
REQ-010 gyroData  out  16  gyro X raw rate, two's complement, registered.
REQ-011 y_accel_data  out  16  accel Y raw, two's complement, registered.
REQ-012 z_accel_data  out  16  accel Z raw, two's complement, registered.
REQ-013 data_valid  out  1  one-cycle pulse when all three data outputs update together.
REQ-014 overrun  out  1  one-cycle pulse when a sample tick arrives while a frame is still in progress.

Function
REQ-015 Free-running tick counter wraps 0..SAMPLE_DIV-1; a tick is asserted for one cycle when the count is 0.
REQ-016 FSM states: IDLE, G_SETUP, G_XFER, G_HOLD, GAP, A_SETUP, A_XFER, A_HOLD, PUBLISH.
REQ-017 IDLE -> G_SETUP on tick; gyro_cs_n falls in the cycle after the tick.
REQ-018 SETUP and HOLD states last CLK_DIV clocks each with CS low and SCLK high; GAP lasts CLK_DIV clocks with both CS high.
REQ-019 G_XFER shifts 3 bytes: command 0xE8 (read, auto-increment, address 0x28), then two dummy 0x00 bytes; received bytes 2 and 3 are X_L and X_H.
REQ-020 A_XFER shifts 5 bytes: command 0xF4 (read, multi-byte, address 0x34), then four dummy 0x00 bytes; received bytes 2..5 are Y0, Y1, Z0, Z1.
REQ-021 Byte timing: SCLK falls, MOSI changes on the falling edge, MISO is sampled on the rising edge, MSB first; 16*CLK_DIV clocks per byte; no idle SCLK between bytes within one transaction.
REQ-022 Words are assembled little-endian as {high, low} into shadow registers; outputs stay unchanged until PUBLISH.
REQ-023 PUBLISH lasts 1 cycle and copies the shadow registers to gyroData/y_accel_data/z_accel_data; data_valid is high in the same cycle; next state is IDLE.
REQ-024 Latency: data_valid is asserted exactly 133*CLK_DIV+2 cycles after the tick cycle.
REQ-025 Tick outside IDLE: tick is dropped, overrun is pulsed, and the current frame continues unaffected.
REQ-026 Tick in the same cycle as PUBLISH is treated as an overrun; no frame starts until the next tick.
REQ-027 gyro_cs_n and accel_cs_n are never low in the same cycle.
REQ-028 spi_sclk is high whenever both chip selects are high.

Reset
REQ-029 While RST=1 at a clk edge: state=IDLE, tick counter=1, spi_sclk=1, spi_mosi=0, gyro_cs_n=1, accel_cs_n=1, data_valid=0, overrun=0, all data outputs and shadow registers=0.
REQ-030 Reset asserted mid-transaction aborts the transaction in the next cycle (both CS high, SCLK high) with no data_valid pulse; the first tick after release occurs SAMPLE_DIV-1 cycles later.

Structure
REQ-031 A shared package/include holds the command bytes (0xE8, 0xF4), byte counts (3, 5), and FSM state encodings.
REQ-032 Sub-module spi_byte_shifter (one byte, mode 3, CLK_DIV parameter, start/done handshake) is instantiated once and time-shared by both transactions.

Verification
REQ-033 CLK_DIV=2, SAMPLE_DIV=400; gyro model returns X=0x1234 and accel model returns Y=0xFF80, Z=0x0100 -> data_valid at tick+268 with gyroData=0x1234, y_accel_data=0xFF80, z_accel_data=0x0100.
REQ-034 Capture MOSI bytes -> gyro transaction shows E8 00 00; accel transaction shows F4 00 00 00 00; chip selects never overlap; 24 SCLK rising edges in the gyro transaction, 40 in the accel transaction.
REQ-035 SAMPLE_DIV=200 (< 268) -> overrun pulses on the ticks that arrive mid-frame, every frame completes, data_valid occurs once per completed frame.
REQ-036 Assert RST for 1 cycle during the 2nd accel byte -> both CS high and SCLK high the next cycle; no data_valid; outputs hold 0 until the next complete frame.
REQ-037 Two consecutive frames with gyro X = 0x7FFF then 0x8000 -> outputs change only in the data_valid cycle and keep their value between pulses.
